// File: rtl/mask_unit_read_response_cross_bar_pkg.sv
// Shared types and helpers for the mask-unit read-response crossbar.
//   LANE_NUM / LANE_IDX_W : four lanes, two-bit lane/requester index
//   DATA_OFFSET_W         : width of the echoed data offset
//   resp_t                : one read response (data, writeIndex, dataOffset, readLane)
//   rr_pick()             : round-robin pick starting at a given lane
package mask_unit_read_response_cross_bar_pkg;

    localparam int LANE_NUM      = 4;
    localparam int LANE_IDX_W    = 2;
    localparam int DATA_OFFSET_W = 2;
    localparam int RESP_DATA_W   = 32;

    typedef struct packed {
        logic [RESP_DATA_W-1:0]   data;
        logic [LANE_IDX_W-1:0]    write_index;
        logic [DATA_OFFSET_W-1:0] data_offset;
        logic [LANE_IDX_W-1:0]    read_lane;
    } resp_t;

    typedef struct packed {
        logic                  found;
        logic [LANE_IDX_W-1:0] lane;
    } rr_grant_t;

    // Picks the first requesting lane at or after 'start', wrapping around.
    // Scanning from the farthest candidate down lets the nearest one win last.
    function automatic rr_grant_t rr_pick(input logic [LANE_NUM-1:0]   req,
                                          input logic [LANE_IDX_W-1:0] start);
        rr_grant_t             g;
        logic [LANE_IDX_W-1:0] cand;
        g.found = 1'b0;
        g.lane  = 2'b00;
        for (int k = LANE_NUM - 1; k >= 0; k--) begin
            cand = start + LANE_IDX_W'(k);
            if (req[cand]) begin
                g.found = 1'b1;
                g.lane  = cand;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mask_unit_read_response_cross_bar_if.sv
// Bundle of the lane-side and requester-side response handshakes.
//   in_*  : four lane response ports (valid/ready, data, writeIndex, dataOffset)
//   out_* : four requester return ports (valid/ready, data, dataOffset, readLane)
// Modports: master = environment driving lanes and consuming returns,
//           slave  = the crossbar.
interface mask_unit_read_response_cross_bar_if
    import mask_unit_read_response_cross_bar_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic [LANE_NUM-1:0]                    in_valid;
    logic [LANE_NUM-1:0]                    in_ready;
    logic [LANE_NUM-1:0][DATA_W-1:0]        in_bits_data;
    logic [LANE_NUM-1:0][LANE_IDX_W-1:0]    in_bits_write_index;
    logic [LANE_NUM-1:0][DATA_OFFSET_W-1:0] in_bits_data_offset;

    logic [LANE_NUM-1:0]                    out_valid;
    logic [LANE_NUM-1:0]                    out_ready;
    logic [LANE_NUM-1:0][DATA_W-1:0]        out_bits_data;
    logic [LANE_NUM-1:0][DATA_OFFSET_W-1:0] out_bits_data_offset;
    logic [LANE_NUM-1:0][LANE_IDX_W-1:0]    out_bits_read_lane;

    modport master (
        output in_valid, in_bits_data, in_bits_write_index, in_bits_data_offset, out_ready,
        input  in_ready, out_valid, out_bits_data, out_bits_data_offset, out_bits_read_lane
    );

    modport slave (
        input  in_valid, in_bits_data, in_bits_write_index, in_bits_data_offset, out_ready,
        output in_ready, out_valid, out_bits_data, out_bits_data_offset, out_bits_read_lane
    );
endinterface

// File: rtl/mask_unit_read_response_cross_bar_fifo.sv
// mask_unit_resp_fifo: synchronous FIFO with registered storage and head output.
//   clk_i/rst_ni : clock, async active-low reset (clears storage and pointers)
//   push_i/data_i: write request (ignored while full, even with a pop)
//   pop_i        : read request (ignored while empty)
//   full_o/empty_o/data_o : status and head entry
module mask_unit_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == CNT_W'(0));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage, pointers (wrap naturally, depth is a power of two) and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/mask_unit_read_response_cross_bar.sv
// Read-response crossbar: routes each lane response to the requester named by
// its writeIndex through a per-requester round-robin arbiter and return FIFO.
//   clock, reset_n : clock, async active-low reset
//   resp_bus       : slave side of mask_unit_read_response_cross_bar_if
// Optional macro MASK_UNIT_RESP_BYPASS_EN: an empty FIFO whose requester is
// ready passes the granted response straight through in the same cycle.
// Without it, in_ready depends only on registered FIFO state.
module mask_unit_read_response_cross_bar
    import mask_unit_read_response_cross_bar_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input logic                                 clock,
    input logic                                 reset_n,
    mask_unit_read_response_cross_bar_if.slave  resp_bus
);
    localparam int ENTRY_W = DATA_W + DATA_OFFSET_W + LANE_IDX_W;

    logic [LANE_NUM-1:0][LANE_IDX_W-1:0] rr_ptr_q;   // first lane to consider
    logic [LANE_NUM-1:0][LANE_IDX_W-1:0] rr_ptr_d;
    logic [LANE_NUM-1:0][LANE_NUM-1:0]   req_s;      // [requester][lane]
    rr_grant_t [LANE_NUM-1:0]            grant_s;
    logic [LANE_NUM-1:0]                 accept_s;
    logic [LANE_NUM-1:0]                 fifo_full_s;
    logic [LANE_NUM-1:0]                 fifo_empty_s;
    logic [LANE_NUM-1:0]                 fifo_push_s;
    logic [LANE_NUM-1:0]                 fifo_pop_s;
    logic [LANE_NUM-1:0][ENTRY_W-1:0]    fifo_wdata_s;
    logic [LANE_NUM-1:0][ENTRY_W-1:0]    fifo_rdata_s;
    logic [LANE_NUM-1:0][ENTRY_W-1:0]    out_word_s;

    // Per-requester arbitration; a grant is accepted only when its FIFO has room.
    always_comb begin
        for (int j = 0; j < LANE_NUM; j++) begin
            for (int i = 0; i < LANES; i++) begin
                req_s[j][i] = resp_bus.in_valid[i] &&
                              (resp_bus.in_bits_write_index[i] == LANE_IDX_W'(j));
            end
            grant_s[j]      = rr_pick(req_s[j], rr_ptr_q[j]);
            accept_s[j]     = reset_n && grant_s[j].found && !fifo_full_s[j];
            fifo_wdata_s[j] = {resp_bus.in_bits_data[grant_s[j].lane],
                               resp_bus.in_bits_data_offset[grant_s[j].lane],
                               grant_s[j].lane};
            if (accept_s[j]) begin
                rr_ptr_d[j] = grant_s[j].lane + LANE_IDX_W'(1);
            end else begin
                rr_ptr_d[j] = rr_ptr_q[j];
            end
        end
    end

    // A lane is ready when it holds the accepted grant of its target requester.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            resp_bus.in_ready[i] =
                accept_s[resp_bus.in_bits_write_index[i]] &&
                (grant_s[resp_bus.in_bits_write_index[i]].lane == LANE_IDX_W'(i));
        end
    end

    // Requester-side output selection, FIFO push and pop.
    always_comb begin
        for (int j = 0; j < LANE_NUM; j++) begin
`ifdef MASK_UNIT_RESP_BYPASS_EN
            fifo_push_s[j] = accept_s[j] && !(fifo_empty_s[j] && resp_bus.out_ready[j]);
            if (fifo_empty_s[j]) begin
                resp_bus.out_valid[j] = accept_s[j];
                out_word_s[j]         = fifo_wdata_s[j];
            end else begin
                resp_bus.out_valid[j] = 1'b1;
                out_word_s[j]         = fifo_rdata_s[j];
            end
`else
            fifo_push_s[j]        = accept_s[j];
            resp_bus.out_valid[j] = !fifo_empty_s[j];
            out_word_s[j]         = fifo_rdata_s[j];
`endif
            fifo_pop_s[j] = !fifo_empty_s[j] && resp_bus.out_ready[j];
            {resp_bus.out_bits_data[j],
             resp_bus.out_bits_data_offset[j],
             resp_bus.out_bits_read_lane[j]} = out_word_s[j];
        end
    end

    // Round-robin pointers; lane 0 has first priority after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= {(LANE_NUM * LANE_IDX_W){1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar j = 0; j < LANE_NUM; j++) begin : g_fifo
        mask_unit_resp_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk_i   (clock),
            .rst_ni  (reset_n),
            .push_i  (fifo_push_s[j]),
            .data_i  (fifo_wdata_s[j]),
            .pop_i   (fifo_pop_s[j]),
            .full_o  (fifo_full_s[j]),
            .empty_o (fifo_empty_s[j]),
            .data_o  (fifo_rdata_s[j])
        );
    end
endmodule

// File: tb/tb_mask_unit_read_response_cross_bar.sv
// Scoreboard bench for mask_unit_read_response_cross_bar (default build).
// The reference model keeps, per requester, a queue of responses held in its
// return FIFO and the last granted lane; acceptance is decided from queue size.
module tb_mask_unit_read_response_cross_bar;
    import mask_unit_read_response_cross_bar_pkg::*;

    localparam int DEPTH = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    mask_unit_read_response_cross_bar_if #(.DATA_W(32)) bus ();

    mask_unit_read_response_cross_bar #(
        .LANES      (4),
        .DATA_W     (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .resp_bus (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    resp_t      lane_item [4];
    logic [3:0] pending  = 4'h0;
    logic [3:0] accepted = 4'h0;
    resp_t      sb [4][$];
    int         rr_last [4] = '{3, 3, 3, 3};
    int         grant_log [$];

    int         gen_mode   = 0;   // 0 idle, 1 random, 2 all lanes to requester 0, 3 burst
    logic [3:0] ordy_fixed = 4'hF;
    bit         ordy_rand  = 1'b0;
    int         m3_lane = 0, m3_dst = 0, m3_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic new_item(input int i, input logic [1:0] wi, input logic [31:0] d);
        lane_item[i].data        = d;
        lane_item[i].write_index = wi;
        lane_item[i].data_offset = 2'($urandom);
        lane_item[i].read_lane   = 2'(i);
        pending[i]               = 1'b1;
    endtask

    // Retire accepted lanes, generate new stimulus, drive the bus.
    task automatic apply();
        pending  = pending & ~accepted;
        accepted = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (!pending[i]) begin
                case (gen_mode)
                    1: if ($urandom_range(0, 1) == 1) new_item(i, 2'($urandom), $urandom);
                    2: new_item(i, 2'd0, $urandom);
                    3: if (i == m3_lane && m3_left > 0) begin
                           new_item(i, 2'(m3_dst), 32'hC0DE_0000 + 32'(m3_left));
                           m3_left--;
                       end
                    default: ;
                endcase
            end
        end
        bus.in_valid = pending;
        for (int i = 0; i < 4; i++) begin
            bus.in_bits_data[i]        = lane_item[i].data;
            bus.in_bits_write_index[i] = lane_item[i].write_index;
            bus.in_bits_data_offset[i] = lane_item[i].data_offset;
        end
        bus.out_ready = ordy_rand ? 4'($urandom) : ordy_fixed;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        apply();
        @(negedge clock);
        #1;
    endtask

    // Monitor + reference model, evaluated away from the active edge.
    always @(negedge clock) begin : mon
        bit         full [4];
        logic [3:0] exp_ready;
        int         win;
        int         lane;
        resp_t      e;
        if (!reset_n) begin
            chk("reset_in_ready", 32'(bus.in_ready), 32'h0);
            chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
            for (int j = 0; j < 4; j++) begin
                sb[j].delete();
                rr_last[j] = 3;
            end
            accepted = 4'h0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                full[j] = (sb[j].size() == DEPTH);
                chk($sformatf("out_valid[%0d]", j), 32'(bus.out_valid[j]), 32'(sb[j].size() != 0));
                if (bus.out_valid[j] && bus.out_ready[j] && sb[j].size() != 0) begin
                    e = sb[j][0];
                    chk($sformatf("out_data[%0d]", j), bus.out_bits_data[j], e.data);
                    chk($sformatf("out_offset[%0d]", j), 32'(bus.out_bits_data_offset[j]), 32'(e.data_offset));
                    chk($sformatf("out_read_lane[%0d]", j), 32'(bus.out_bits_read_lane[j]), 32'(e.read_lane));
                    void'(sb[j].pop_front());
                end
            end
            exp_ready = 4'h0;
            for (int j = 0; j < 4; j++) begin
                win = -1;
                for (int k = 1; k <= 4; k++) begin
                    lane = (rr_last[j] + k) % 4;
                    if (win < 0 && pending[lane] && lane_item[lane].write_index == 2'(j)) win = lane;
                end
                if (win >= 0 && !full[j]) begin
                    exp_ready[win] = 1'b1;
                    rr_last[j]     = win;
                    e              = lane_item[win];
                    e.read_lane    = 2'(win);
                    sb[j].push_back(e);
                    if (j == 0) grant_log.push_back(win);
                end
            end
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            accepted = exp_ready;
        end
    end

    initial begin
        apply();
        repeat (2) @(posedge clock);
        // Release reset with all lanes already aiming at requester 0.
        grant_log.delete();
        gen_mode = 2;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        apply();
        @(negedge clock);
        #1;
        chk("first_push_ready", 32'(bus.in_ready), 32'h1);
        repeat (7) step();
        gen_mode = 0;
        chk("grant_log_len", 32'(grant_log.size() >= 5), 32'h1);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) chk($sformatf("rr_grant[%0d]", k), 32'(grant_log[k]), 32'(k % 4));
        end
        repeat (8) step();

        // Single response lane 2 -> requester 1.
        lane_item[2] = '{data: 32'hDEADBEEF, write_index: 2'd1, data_offset: 2'd3, read_lane: 2'd2};
        pending[2]   = 1'b1;
        step();
        chk("single_in_ready", 32'(bus.in_ready), 32'h4);
        step();
        chk("single_out_valid", 32'(bus.out_valid), 32'h2);
        chk("single_data", bus.out_bits_data[1], 32'hDEADBEEF);
        chk("single_offset", 32'(bus.out_bits_data_offset[1]), 32'h3);
        chk("single_lane", 32'(bus.out_bits_read_lane[1]), 32'h2);
        repeat (2) step();

        // Four lanes to four distinct requesters in one cycle.
        for (int i = 0; i < 4; i++) begin
            lane_item[i] = '{data: 32'h3300_0000 + 32'(i), write_index: 2'(3 - i),
                             data_offset: 2'(i), read_lane: 2'(i)};
        end
        pending = 4'hF;
        step();
        chk("parallel_in_ready", 32'(bus.in_ready), 32'hF);
        step();
        chk("parallel_out_valid", 32'(bus.out_valid), 32'hF);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("parallel_lane[%0d]", j), 32'(bus.out_bits_read_lane[j]), 32'(3 - j));
        end
        repeat (2) step();

        // Back-pressure on requester 2: third response must wait.
        ordy_fixed = 4'b1011;
        gen_mode = 3; m3_lane = 1; m3_dst = 2; m3_left = 3;
        repeat (3) step();
        chk("full_in_ready1", 32'(bus.in_ready[1]), 32'h0);
        chk("full_out_valid2", 32'(bus.out_valid[2]), 32'h1);
        step();
        chk("full_in_ready1_hold", 32'(bus.in_ready[1]), 32'h0);
        ordy_fixed = 4'hF;
        repeat (6) step();
        gen_mode = 0;

        // Reset with two responses buffered for requester 0.
        ordy_fixed = 4'b1110;
        gen_mode = 3; m3_lane = 0; m3_dst = 0; m3_left = 2;
        repeat (4) step();
        chk("prereset_out_valid0", 32'(bus.out_valid[0]), 32'h1);
        gen_mode = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        pending = 4'h0;
        apply();
        #1;
        chk("async_reset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("async_reset_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        reset_n = 1'b1;
        ordy_fixed = 4'hF;
        repeat (3) step();
        chk("postreset_out_valid0", 32'(bus.out_valid[0]), 32'h0);
        chk("postreset_out_data0", bus.out_bits_data[0], 32'h0);

        // Randomised traffic and back-pressure.
        gen_mode = 1;
        ordy_rand = 1'b1;
        repeat (400) step();
        gen_mode = 0;
        ordy_rand = 1'b0;
        ordy_fixed = 4'hF;
        repeat (12) step();
        chk("drained_out_valid", 32'(bus.out_valid), 32'h0);
        chk("drained_lanes", 32'(pending), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
